// File: rtl/control_unit.sv
// Main instruction decoder: maps the 7-bit opcode to the datapath control
// word, registered so every control output appears one clock after sampling.
package control_unit_pkg;
    typedef enum logic [6:0] {
        OP_RTYPE  = 7'b0110011,
        OP_ITYPE  = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_LUI    = 7'b0110111
    } opcode_e;
endpackage

module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  opcode_e    opcodes_i,
    output logic       regwrite_o,
    output logic       memrd_o,
    output logic       memw_o,
    output logic       memtoreg_o,
    output logic       opBsel_o,
    output logic       branch_o,
    output logic [1:0] opAsel_o,
    output logic [1:0] extendsel_o,
    output logic [1:0] nextPCsel_o,
    output logic [2:0] aluop_o
);

    typedef struct packed {
        logic       regwrite;
        logic       memrd;
        logic       memw;
        logic       memtoreg;
        logic       opbsel;
        logic       branch;
        logic [1:0] opasel;
        logic [1:0] extendsel;
        logic [1:0] nextpcsel;
        logic [2:0] aluop;
    } ctrl_t;

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    always_comb begin
        ctrl_d = '0;
        case (opcodes_i)
            OP_RTYPE:  ctrl_d = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000};
            OP_ITYPE:  ctrl_d = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b001};
            OP_LOAD:   ctrl_d = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b100};
            OP_STORE:  ctrl_d = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 3'b101};
            OP_BRANCH: ctrl_d = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 3'b010};
            OP_JALR:   ctrl_d = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b11, 3'b011};
            OP_JAL:    ctrl_d = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b011};
            OP_LUI:    ctrl_d = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b10, 2'b00, 3'b110};
            // Unknown opcodes become a NOP: no register or memory side effects.
            default:   ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign regwrite_o  = ctrl_q.regwrite;
    assign memrd_o     = ctrl_q.memrd;
    assign memw_o      = ctrl_q.memw;
    assign memtoreg_o  = ctrl_q.memtoreg;
    assign opBsel_o    = ctrl_q.opbsel;
    assign branch_o    = ctrl_q.branch;
    assign opAsel_o    = ctrl_q.opasel;
    assign extendsel_o = ctrl_q.extendsel;
    assign nextPCsel_o = ctrl_q.nextpcsel;
    assign aluop_o     = ctrl_q.aluop;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset, per-opcode decode rows, illegal
// opcode, and asynchronous mid-sequence reset.
module tb_control_unit;
    import control_unit_pkg::*;

    logic       clk_i;
    logic       rst_i;
    opcode_e    opcodes_i;
    logic       regwrite_o;
    logic       memrd_o;
    logic       memw_o;
    logic       memtoreg_o;
    logic       opBsel_o;
    logic       branch_o;
    logic [1:0] opAsel_o;
    logic [1:0] extendsel_o;
    logic [1:0] nextPCsel_o;
    logic [2:0] aluop_o;

    logic [14:0] word;

    int n_cmp;
    int n_bad;

    // Hand-computed rows: rw,mr,mw,mtr,bsel,br,asel,ext,npc,aluop
    localparam logic [14:0] ROW_RTYPE  = 15'b100000_00_00_00_000;
    localparam logic [14:0] ROW_ITYPE  = 15'b100010_00_00_00_001;
    localparam logic [14:0] ROW_LOAD   = 15'b110110_00_00_00_100;
    localparam logic [14:0] ROW_STORE  = 15'b001010_00_01_00_101;
    localparam logic [14:0] ROW_BRANCH = 15'b000001_00_00_01_010;
    localparam logic [14:0] ROW_JALR   = 15'b100000_10_00_11_011;
    localparam logic [14:0] ROW_JAL    = 15'b100000_10_00_10_011;
    localparam logic [14:0] ROW_LUI    = 15'b100010_11_10_00_110;
    localparam logic [14:0] ROW_ZERO   = 15'b0;

    control_unit dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .opcodes_i   (opcodes_i),
        .regwrite_o  (regwrite_o),
        .memrd_o     (memrd_o),
        .memw_o      (memw_o),
        .memtoreg_o  (memtoreg_o),
        .opBsel_o    (opBsel_o),
        .branch_o    (branch_o),
        .opAsel_o    (opAsel_o),
        .extendsel_o (extendsel_o),
        .nextPCsel_o (nextPCsel_o),
        .aluop_o     (aluop_o)
    );

    assign word = {regwrite_o, memrd_o, memw_o, memtoreg_o, opBsel_o, branch_o,
                   opAsel_o, extendsel_o, nextPCsel_o, aluop_o};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic apply(input opcode_e op, input logic [14:0] exp, input string tag);
        @(negedge clk_i);
        opcodes_i = op;
        @(posedge clk_i);
        #1;
        check(tag, word, exp);
        check({tag, "_excl"}, {13'b0, memw_o & regwrite_o, memw_o & memrd_o}, 15'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_i = 1'b1;
        opcodes_i = OP_RTYPE;
        #1;
        check("reset_no_edge", word, ROW_ZERO);
        @(posedge clk_i);
        #1;
        check("reset_held_edge", word, ROW_ZERO);

        // Release between edges; first edge loads the opcode present then.
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("release_before_edge", word, ROW_ZERO);
        @(posedge clk_i);
        #1;
        check("first_edge_rtype", word, ROW_RTYPE);

        apply(OP_ITYPE,  ROW_ITYPE,  "itype");
        apply(OP_LOAD,   ROW_LOAD,   "load");
        apply(OP_STORE,  ROW_STORE,  "store");
        apply(OP_BRANCH, ROW_BRANCH, "branch");
        apply(OP_JALR,   ROW_JALR,   "jalr");
        apply(OP_JAL,    ROW_JAL,    "jal");
        apply(OP_LUI,    ROW_LUI,    "lui");
        apply(OP_RTYPE,  ROW_RTYPE,  "rtype");

        apply(opcode_e'(7'b1111111), ROW_ZERO, "illegal_7f");
        apply(OP_LOAD,               ROW_LOAD, "load_after_illegal");
        apply(opcode_e'(7'b0000000), ROW_ZERO, "illegal_00");
        apply(OP_JAL,                ROW_JAL,  "jal_2");
        apply(opcode_e'(7'b1100110), ROW_ZERO, "illegal_near_jalr");
        apply(OP_JALR,               ROW_JALR, "jalr_2");
        apply(OP_LUI,                ROW_LUI,  "lui_before_rst");

        // Pulse reset between edges with a new opcode pending.
        @(negedge clk_i);
        opcodes_i = OP_STORE;
        #1;
        check("pre_pulse_lui", word, ROW_LUI);
        rst_i = 1'b1;
        #1;
        check("async_clear", word, ROW_ZERO);
        rst_i = 1'b0;
        #1;
        check("after_pulse_no_edge", word, ROW_ZERO);
        @(posedge clk_i);
        #1;
        check("post_pulse_store", word, ROW_STORE);

        apply(OP_ITYPE, ROW_ITYPE, "itype_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
